spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Transaction sequencer and arbiter in front of the byte-wide SPI shift engine.
- Accepts burst requests from two requesters (0 = core, 1 = boot/DMA) and grants one.
- Drives the engine's load/unload strobes byte by byte and holds a per-burst chip select.
- Returns each received byte to the granted requester.

Parameters:
- LEN_W, 4: width of burst length field; burst = len+1 bytes (1..16).
- SHIFT_CYC, 8: clock_in cycles the engine needs to shift one byte after load.
- GAP_CYC, 1: idle cycles between bytes of a burst (0 allowed).

Ports:
- clock_in  in  1  system clock; all logic rises on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester burst request; level, held until done.
- req_len  in  2*LEN_W  per-requester burst length-1; [LEN_W-1:0] = requester 0.
- tx_data  in  16  per-requester next tx byte; [7:0] = requester 0.
- gnt  out  2  one-hot grant, held for whole burst.
- tx_ack  out  2  one-cycle pulse: tx byte of that requester consumed.
- rx_data  out  8  last received byte, shared.
- rx_valid  out  2  one-cycle pulse to granted requester: rx_data valid.
- done  out  2  one-cycle pulse at burst end.
- busy  out  1  high in any state other than IDLE.
- cs_n  out  1  active-low chip select for the whole burst.
- shf_load  out  1  load strobe to shift engine.
- shf_txdata  out  8  byte presented with shf_load.
- shf_unload  out  1  unload strobe to shift engine.
- shf_rxdata  in  8  engine parallel output.

Behaviour:
- Reset values: gnt=0, tx_ack=0, rx_valid=0, done=0, busy=0, cs_n=1, shf_load=0, shf_unload=0, shf_txdata=0, rx_data=0; FSM=IDLE; byte and cycle counters=0.
- IDLE:
  - When req!=0, register the winner into gnt, latch its req_len into the byte counter, set cs_n=0 → SETUP.
  - Fixed priority: requester 0 wins.
- SETUP (1 cycle): cs_n low one cycle before the first load → LOAD.
- LOAD (1 cycle):
  - shf_load=1 and shf_txdata = granted tx_data slice.
  - tx_ack[granted]=1.
  - Clear the cycle counter → SHIFT.
- SHIFT: stay SHIFT_CYC cycles, counter 0..SHIFT_CYC-1, then → UNLOAD.
- UNLOAD (1 cycle): shf_unload=1 → CAPTURE.
- CAPTURE (1 cycle):
  - rx_data <= shf_rxdata; rx_valid[granted] pulses in the same cycle as the registered value.
  - If byte counter==0 → END.
  - Else decrement, then → GAP if GAP_CYC>0, otherwise → LOAD.
- GAP: GAP_CYC cycles, cs_n stays low → LOAD.
- END (1 cycle): done[granted]=1, cs_n=1, gnt cleared → IDLE.
- Rearbitration happens only in IDLE, so the next burst's cs_n falls no earlier than 1 cycle after END.
- Per-byte latency, load to rx_valid: SHIFT_CYC+2 cycles.
- Boundary cases:
  - req_len=0: a single byte.
  - req_len=all-ones: 2^LEN_W bytes, no counter wrap.
  - Dropping req mid-burst is ignored; the burst completes.
  - req_len and tx_data are sampled only at grant / LOAD respectively.
  - Both requests rising together: arbitration rule decides.
  - reset_n low mid-burst: immediate return to reset values; cs_n=1 asynchronously.
- Strobes are registered outputs, never combinational from inputs.

Optional Feature:
SPI_RR_ARB_EN
- Defined: round-robin arbitration. A 1-bit last-granted register (reset 1, so requester 0 wins first) gives the non-last requester priority when both request in IDLE.
- Undefined: fixed priority, requester 0 always wins; no last-granted register.

Decomposition:
- Package spi_ctrl_pkg:
  - FSM state enum: IDLE, SETUP, LOAD, SHIFT, UNLOAD, CAPTURE, GAP, END.
  - NREQ=2 constant.
  - Default SHIFT_CYC/GAP_CYC.
- One natural sub-module: spi_req_arb, containing the grant logic (fixed / round-robin under SPI_RR_ARB_EN) and the last-granted register.

Test Plan:
- Reset: assert reset_n=0 mid-SHIFT of a 4-byte burst → cs_n=1, gnt=0, busy=0 immediately; after release a new req0 runs normally from SETUP.
- Single byte: req0=1, req_len0=0, tx_data0=8'hA5, shf_rxdata=8'h3C → tx_ack[0] at LOAD, shf_load with shf_txdata=A5, shf_unload after 8 shift cycles, rx_data=3C with rx_valid[0], done[0] next, cs_n low for exactly the burst.
- Burst: req1 alone, req_len1=2, GAP_CYC=1 → 3 tx_ack[1], 3 rx_valid[1] pulses spaced SHIFT_CYC+GAP_CYC+3 cycles apart, cs_n held low throughout, one done[1].
- Contention, fixed priority: req0 and req1 high every IDLE → gnt always 01; requester 1 starves.
- Contention with SPI_RR_ARB_EN: both held high across 4 bursts → grants alternate 01, 10, 01, 10; cs_n high at least 1 cycle between bursts.
- Max length: req_len0=4'hF → exactly 16 rx_valid pulses, then done; counter does not wrap into a 17th byte.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI transaction sequencer: FSM encoding, requester count,
// default engine timing.
package spi_ctrl_pkg;

  localparam int NREQ          = 2;
  localparam int SHIFT_CYC_DEF = 8;
  localparam int GAP_CYC_DEF   = 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETUP   = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_SHIFT   = 3'd3;
  localparam state_t ST_UNLOAD  = 3'd4;
  localparam state_t ST_CAPTURE = 3'd5;
  localparam state_t ST_GAP     = 3'd6;
  localparam state_t ST_END     = 3'd7;

endpackage

// File: rtl/spi_req_arb.sv
// Two-requester grant logic. SPI_RR_ARB_EN selects round-robin with a last-granted
// register; otherwise requester 0 has fixed priority.
module spi_req_arb
  import spi_ctrl_pkg::*;
(
`ifdef SPI_RR_ARB_EN
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            take_i,
`endif
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] win_o
);

`ifdef SPI_RR_ARB_EN
  // Reset value 1 so requester 0 wins the first contested round.
  logic last_q;

  always_comb begin
    win_o = 2'b00;
    if (&req_i)        win_o = last_q ? 2'b01 : 2'b10;
    else if (req_i[0]) win_o = 2'b01;
    else if (req_i[1]) win_o = 2'b10;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               last_q <= 1'b1;
    else if (take_i && |req_i) last_q <= win_o[1];
  end
`else
  always_comb begin
    win_o = 2'b00;
    if (req_i[0])      win_o = 2'b01;
    else if (req_i[1]) win_o = 2'b10;
  end
`endif

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Burst sequencer/arbiter in front of a byte-wide SPI shift engine. All strobes are
// registered. Optional macro SPI_RR_ARB_EN enables round-robin arbitration.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int LEN_W     = 4,
  parameter int SHIFT_CYC = SHIFT_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*LEN_W-1:0]   req_len,
  input  logic [15:0]          tx_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      tx_ack,
  output logic [7:0]           rx_data,
  output logic [NREQ-1:0]      rx_valid,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 cs_n,
  output logic                 shf_load,
  output logic [7:0]           shf_txdata,
  output logic                 shf_unload,
  input  logic [7:0]           shf_rxdata
);

  localparam int CYC_MAX = (SHIFT_CYC > GAP_CYC) ? SHIFT_CYC : GAP_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] SHIFT_LAST = CYC_W'(SHIFT_CYC - 1);
  localparam logic [CYC_W-1:0] GAP_LAST   = CYC_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   tx_ack_q, tx_ack_d;
  logic [NREQ-1:0]   rx_valid_q, rx_valid_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [7:0]        txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              cs_n_q, cs_n_d;
  logic              load_q, load_d;
  logic              unload_q, unload_d;
  logic [LEN_W-1:0]  byte_q, byte_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [NREQ-1:0]   win;
  logic              go_load;

  spi_req_arb u_arb (
`ifdef SPI_RR_ARB_EN
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .take_i (state_q == ST_IDLE),
`endif
    .req_i  (req),
    .win_o  (win)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cs_n_d     = cs_n_q;
    byte_d     = byte_q;
    cyc_d      = cyc_q;
    rx_data_d  = rx_data_q;
    txd_d      = txd_q;
    load_d     = 1'b0;
    unload_d   = 1'b0;
    tx_ack_d   = '0;
    rx_valid_d = '0;
    done_d     = '0;
    go_load    = 1'b0;

    case (state_q)
      ST_IDLE: if (|req) begin
        gnt_d   = win;
        byte_d  = win[1] ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
        cs_n_d  = 1'b0;
        state_d = ST_SETUP;
      end
      ST_SETUP: go_load = 1'b1;
      ST_LOAD: begin
        cyc_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cyc_q == SHIFT_LAST) begin
          unload_d = 1'b1;
          state_d  = ST_UNLOAD;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_UNLOAD: begin
        rx_data_d  = shf_rxdata;
        rx_valid_d = gnt_q;
        state_d    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (byte_q == '0) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = ST_END;
        end else begin
          byte_d = byte_q - LEN_W'(1);
          if (GAP_CYC > 0) begin
            cyc_d   = '0;
            state_d = ST_GAP;
          end else begin
            go_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (cyc_q == GAP_LAST) go_load = 1'b1;
        else                   cyc_d   = cyc_q + CYC_W'(1);
      end
      ST_END: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Load strobe, tx byte and its ack are registered on entry to LOAD.
    if (go_load) begin
      state_d  = ST_LOAD;
      load_d   = 1'b1;
      txd_d    = gnt_q[1] ? tx_data[15:8] : tx_data[7:0];
      tx_ack_d = gnt_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      tx_ack_q   <= '0;
      rx_valid_q <= '0;
      done_q     <= '0;
      rx_data_q  <= '0;
      txd_q      <= '0;
      busy_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      load_q     <= 1'b0;
      unload_q   <= 1'b0;
      byte_q     <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      tx_ack_q   <= tx_ack_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      cs_n_q     <= cs_n_d;
      load_q     <= load_d;
      unload_q   <= unload_d;
      byte_q     <= byte_d;
      cyc_q      <= cyc_d;
    end
  end

  assign gnt        = gnt_q;
  assign tx_ack     = tx_ack_q;
  assign rx_valid   = rx_valid_q;
  assign done       = done_q;
  assign rx_data    = rx_data_q;
  assign busy       = busy_q;
  assign cs_n       = cs_n_q;
  assign shf_load   = load_q;
  assign shf_txdata = txd_q;
  assign shf_unload = unload_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: burst driver pushes expectations, a negedge
// monitor pops and compares whenever the DUT strobes.
module tb_spi_xfer_ctrl;

  localparam int S = 8;
  localparam int G = 1;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b0;
  logic [1:0]  req      = '0;
  logic [7:0]  req_len  = '0;
  logic [15:0] tx_data  = '0;
  logic [7:0]  shf_rxdata = '0;
  logic [1:0]  gnt, tx_ack, rx_valid, done;
  logic [7:0]  rx_data, shf_txdata;
  logic        busy, cs_n, shf_load, shf_unload;

  spi_xfer_ctrl #(.LEN_W(4), .SHIFT_CYC(S), .GAP_CYC(G)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .req(req), .req_len(req_len),
    .tx_data(tx_data), .gnt(gnt), .tx_ack(tx_ack), .rx_data(rx_data),
    .rx_valid(rx_valid), .done(done), .busy(busy), .cs_n(cs_n),
    .shf_load(shf_load), .shf_txdata(shf_txdata), .shf_unload(shf_unload),
    .shf_rxdata(shf_rxdata)
  );

  always #5 clock_in = ~clock_in;

  typedef struct { int w; logic [7:0] b; } ent_t;
  typedef struct { int w; int n; int cs; } burst_t;

  ent_t        exp_tx[$];
  ent_t        exp_rx[$];
  burst_t      exp_done[$];
  logic [1:0]  exp_gnt[$];
  logic [7:0]  txq0[$], txq1[$], rxq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          m_last = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration from the requester pattern alone.
  function automatic int pick_winner(input logic [1:0] pat);
`ifdef SPI_RR_ARB_EN
    if (pat == 2'b11) return (m_last == 1) ? 0 : 1;
`endif
    return pat[0] ? 0 : 1;
  endfunction

  task automatic start_burst(input logic [1:0] pat, input int l0, input int l1, input bit dir);
    int w, n;
    logic [7:0] b;
    logic [3:0] s0, s1;
    txq0.delete(); txq1.delete();
    for (int i = 0; i <= l0; i++) txq0.push_back(8'($urandom));
    for (int i = 0; i <= l1; i++) txq1.push_back(8'($urandom));
    if (dir) txq0[0] = 8'hA5;
    w = pick_winner(pat);
    m_last = w;
    n = ((w == 1) ? l1 : l0) + 1;
    for (int i = 0; i < n; i++) begin
      b = (dir && i == 0) ? 8'h3C : 8'($urandom);
      rxq.push_back(b);
      exp_rx.push_back('{w, b});
      exp_tx.push_back('{w, (w == 1) ? txq1[i] : txq0[i]});
    end
    exp_gnt.push_back((w == 1) ? 2'b10 : 2'b01);
    exp_done.push_back('{w, n, 1 + n * (S + 3) + (n - 1) * G});
    s0 = 4'(l0); s1 = 4'(l1);
    tx_data = {txq1[0], txq0[0]};
    req_len = {s1, s0};
    req     = pat;
  endtask

  task automatic wait_done(input bit drop);
    bit got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clock_in);
      if (drop && tx_ack != 0) req = '0;
      if (done != 0) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL burst_timeout: no done within 400 cycles at %0t", $time);
    end
    req = '0;
  endtask

  // Monitor, stand-in shift engine and requester tx sources.
  initial begin
    int cyc = 0, cs_low = 0, nrx = 0;
    logic [1:0] prev_gnt = '0;
    logic prev_cs_n = 1'b1;
    int load_cyc[$];
    ent_t e;
    burst_t d;
    forever begin
      @(negedge clock_in);
      if (!reset_n) begin
        cs_low = 0; nrx = 0; prev_gnt = '0; prev_cs_n = 1'b1; load_cyc.delete();
      end else begin
        cyc++;
        if (!cs_n) cs_low++;
        if (gnt != 0 && prev_gnt == 0) begin
          chk("cs_gap_before_burst", prev_cs_n, 1'b1);
          if (exp_gnt.size() == 0) chk("gnt_unexpected", gnt, 0);
          else chk("gnt", gnt, exp_gnt.pop_front());
        end
        if (shf_load) begin
          if (exp_tx.size() == 0) chk("load_unexpected", shf_load, 0);
          else begin
            e = exp_tx.pop_front();
            chk("shf_txdata", shf_txdata, e.b);
            chk("tx_ack", tx_ack, 32'(1 << e.w));
            chk("cs_n_at_load", cs_n, 1'b0);
          end
          load_cyc.push_back(cyc);
          if (rxq.size() != 0) shf_rxdata = rxq.pop_front();
        end else if (tx_ack != 0) chk("tx_ack_stray", tx_ack, 0);
        if (rx_valid != 0) begin
          nrx++;
          if (exp_rx.size() == 0) chk("rx_unexpected", rx_valid, 0);
          else begin
            e = exp_rx.pop_front();
            chk("rx_data", rx_data, e.b);
            chk("rx_valid", rx_valid, 32'(1 << e.w));
          end
          if (load_cyc.size() != 0) chk("load_to_rx_latency", cyc - load_cyc.pop_front(), S + 2);
        end
        if (done != 0) begin
          if (exp_done.size() == 0) chk("done_unexpected", done, 0);
          else begin
            d = exp_done.pop_front();
            chk("done", done, 32'(1 << d.w));
            chk("bytes_per_burst", nrx, d.n);
            chk("cs_low_cycles", cs_low, d.cs);
          end
          chk("cs_n_at_end", cs_n, 1'b1);
          chk("gnt_at_end", gnt, 0);
          nrx = 0; cs_low = 0;
        end
        if (tx_ack[0] && txq0.size() != 0) void'(txq0.pop_front());
        if (tx_ack[1] && txq1.size() != 0) void'(txq1.pop_front());
        tx_data[7:0]  = (txq0.size() != 0) ? txq0[0] : 8'h00;
        tx_data[15:8] = (txq1.size() != 0) ? txq1[0] : 8'h00;
        prev_gnt  = gnt;
        prev_cs_n = cs_n;
      end
    end
  end

  initial begin
    int l0, l1;
    logic [1:0] pat;
    bit got;
    repeat (2) @(negedge clock_in);
    chk("rst_gnt", gnt, 0);          chk("rst_cs_n", cs_n, 1);
    chk("rst_busy", busy, 0);        chk("rst_shf_load", shf_load, 0);
    chk("rst_shf_unload", shf_unload, 0); chk("rst_txdata", shf_txdata, 0);
    chk("rst_rx_data", rx_data, 0);  chk("rst_rx_valid", rx_valid, 0);
    chk("rst_done", done, 0);        chk("rst_tx_ack", tx_ack, 0);
    reset_n = 1'b1;
    @(negedge clock_in);

    start_burst(2'b01, 0, 0, 1'b1); wait_done(1'b0);   // single byte A5 / 3C
    start_burst(2'b10, 0, 2, 1'b0); wait_done(1'b0);   // requester 1 alone
    for (int i = 0; i < 4; i++) begin                  // contention
      start_burst(2'b11, 1, 1, 1'b0); wait_done(1'b0);
    end
    start_burst(2'b01, 15, 3, 1'b0); wait_done(1'b0);  // maximum length
    start_burst(2'b01, 0, 0, 1'b0); wait_done(1'b1);   // req dropped after first ack

    // Reset in the middle of a shift.
    start_burst(2'b01, 3, 0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clock_in);
      if (shf_load) got = 1'b1;
    end
    repeat (3) @(negedge clock_in);
    reset_n = 1'b0;
    #1;
    chk("midrst_cs_n", cs_n, 1); chk("midrst_gnt", gnt, 0); chk("midrst_busy", busy, 0);
    chk("midrst_shf_load", shf_load, 0);
    req = '0;
    exp_tx.delete(); exp_rx.delete(); exp_done.delete(); exp_gnt.delete(); rxq.delete();
    txq0.delete(); txq1.delete();
    m_last = 1;
    repeat (3) @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);
    start_burst(2'b01, 1, 0, 1'b0); wait_done(1'b0);

    for (int i = 0; i < 30; i++) begin
      pat = 2'($urandom_range(1, 3));
      l0 = ($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15);
      l1 = ($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15);
      start_burst(pat, l0, l1, 1'b0);
      wait_done($urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clock_in);
    chk("left_tx", exp_tx.size(), 0);
    chk("left_rx", exp_rx.size(), 0);
    chk("left_done", exp_done.size(), 0);
    chk("final_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
